alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit.sv | 160 ++++++++++++++++
 tb/tb_alu_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - integer ALU with branch resolution, fixed latency L=1
// rtl/alu_unit.sv - define ALU_MUL_EN to add the 3-stage MUL/MULH/MULHSU/MULHU pipeline (L=3)
module alu_unit #(
    parameter int ROB_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clr_in,
    input  logic             rs_to_alu_ready,
    input  logic [4:0]       rs_to_alu_op,
    input  logic [2:0]       rs_to_alu_opType,
    input  logic [31:0]      rs_to_alu_rs1,
    input  logic [31:0]      rs_to_alu_rs2,
    input  logic [31:0]      rs_to_alu_imm,
    input  logic [31:0]      rs_to_alu_PC,
    input  logic [ROB_W-1:0] rs_to_alu_rob_index,
    output logic             alu_ready,
    output logic [31:0]      alu_result,
    output logic [ROB_W-1:0] alu_rob_index,
    output logic             alu_jump,
    output logic [31:0]      alu_target_PC
);
    localparam logic [2:0] T_REG = 3'd0, T_IMM = 3'd1, T_LUI = 3'd2, T_AUIPC = 3'd3,
                           T_JAL = 3'd4, T_JALR = 3'd5, T_BRANCH = 3'd6;
    localparam logic [4:0] O_ADD = 5'd0, O_SUB = 5'd1, O_SLL = 5'd2, O_SLT = 5'd3,
                           O_SLTU = 5'd4, O_XOR = 5'd5, O_SRL = 5'd6, O_SRA = 5'd7,
                           O_OR = 5'd8, O_AND = 5'd9, O_BEQ = 5'd10, O_BNE = 5'd11,
                           O_BLT = 5'd12, O_BGE = 5'd13, O_BLTU = 5'd14, O_BGEU = 5'd15,
                           O_MUL = 5'd16, O_MULH = 5'd17, O_MULHSU = 5'd18, O_MULHU = 5'd19;

    logic [31:0] op_b, pc_plus4, pc_plus_imm, c_result, c_target;
    logic [4:0]  shamt;
    logic        c_jump;

    always_comb begin
        op_b        = (rs_to_alu_opType == T_IMM) ? rs_to_alu_imm : rs_to_alu_rs2;
        shamt       = op_b[4:0];
        pc_plus4    = rs_to_alu_PC + 32'd4;
        pc_plus_imm = rs_to_alu_PC + rs_to_alu_imm;
        c_result    = '0;
        c_jump      = 1'b0;
        c_target    = pc_plus4;
        case (rs_to_alu_opType)
            T_REG, T_IMM: begin
                case (rs_to_alu_op)
                    O_ADD:   c_result = rs_to_alu_rs1 + op_b;
                    O_SUB:   c_result = rs_to_alu_rs1 - op_b;
                    O_SLL:   c_result = rs_to_alu_rs1 << shamt;
                    O_SLT:   c_result = {31'b0, $signed(rs_to_alu_rs1) < $signed(op_b)};
                    O_SLTU:  c_result = {31'b0, rs_to_alu_rs1 < op_b};
                    O_XOR:   c_result = rs_to_alu_rs1 ^ op_b;
                    O_SRL:   c_result = rs_to_alu_rs1 >> shamt;
                    O_SRA:   c_result = $signed(rs_to_alu_rs1) >>> shamt;
                    O_OR:    c_result = rs_to_alu_rs1 | op_b;
                    O_AND:   c_result = rs_to_alu_rs1 & op_b;
                    default: c_result = '0;
                endcase
            end
            T_LUI:   c_result = rs_to_alu_imm;
            T_AUIPC: c_result = pc_plus_imm;
            T_JAL: begin
                c_result = pc_plus4;
                c_jump   = 1'b1;
                c_target = pc_plus_imm;
            end
            T_JALR: begin
                c_result = pc_plus4;
                c_jump   = 1'b1;
                c_target = (rs_to_alu_rs1 + rs_to_alu_imm) & ~32'd1;
            end
            T_BRANCH: begin
                case (rs_to_alu_op)
                    O_BEQ:   c_jump = (rs_to_alu_rs1 == op_b);
                    O_BNE:   c_jump = (rs_to_alu_rs1 != op_b);
                    O_BLT:   c_jump = ($signed(rs_to_alu_rs1) < $signed(op_b));
                    O_BGE:   c_jump = ($signed(rs_to_alu_rs1) >= $signed(op_b));
                    O_BLTU:  c_jump = (rs_to_alu_rs1 < op_b);
                    O_BGEU:  c_jump = (rs_to_alu_rs1 >= op_b);
                    default: c_jump = 1'b0;
                endcase
                c_target = c_jump ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    logic             m_is_mul, m_hi, m_sa, m_sb;
    logic             s1_valid, s1_jump, s1_is_mul, s1_hi;
    logic [31:0]      s1_result, s1_target;
    logic [ROB_W-1:0] s1_rob;
    logic [63:0]      s1_a, s1_b;
    logic             s2_valid, s2_jump, s2_is_mul, s2_hi;
    logic [31:0]      s2_result, s2_target;
    logic [ROB_W-1:0] s2_rob;
    logic [63:0]      s2_prod;

    always_comb begin
        m_is_mul = (rs_to_alu_opType == T_REG) && (rs_to_alu_op >= O_MUL) && (rs_to_alu_op <= O_MULHU);
        m_hi     = (rs_to_alu_op != O_MUL);
        m_sa     = (rs_to_alu_op == O_MULH) || (rs_to_alu_op == O_MULHSU);
        m_sb     = (rs_to_alu_op == O_MULH);
    end

    // Operands are pre-extended to 64 bits so a plain 64-bit product gives every signedness mix.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0; s1_jump <= 1'b0; s1_is_mul <= 1'b0; s1_hi <= 1'b0;
            s1_result <= '0; s1_target <= '0; s1_rob <= '0; s1_a <= '0; s1_b <= '0;
            s2_valid <= 1'b0; s2_jump <= 1'b0; s2_is_mul <= 1'b0; s2_hi <= 1'b0;
            s2_result <= '0; s2_target <= '0; s2_rob <= '0; s2_prod <= '0;
            alu_ready <= 1'b0; alu_result <= '0; alu_rob_index <= '0;
            alu_jump <= 1'b0; alu_target_PC <= '0;
        end else if (clr_in) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            alu_ready <= 1'b0;
        end else if (rdy_in) begin
            s1_valid  <= rs_to_alu_ready;
            s1_jump   <= c_jump;
            s1_is_mul <= m_is_mul;
            s1_hi     <= m_hi;
            s1_result <= c_result;
            s1_target <= c_target;
            s1_rob    <= rs_to_alu_rob_index;
            s1_a      <= m_sa ? {{32{rs_to_alu_rs1[31]}}, rs_to_alu_rs1} : {32'b0, rs_to_alu_rs1};
            s1_b      <= m_sb ? {{32{rs_to_alu_rs2[31]}}, rs_to_alu_rs2} : {32'b0, rs_to_alu_rs2};
            s2_valid  <= s1_valid;
            s2_jump   <= s1_jump;
            s2_is_mul <= s1_is_mul;
            s2_hi     <= s1_hi;
            s2_result <= s1_result;
            s2_target <= s1_target;
            s2_rob    <= s1_rob;
            s2_prod   <= s1_a * s1_b;
            alu_ready     <= s2_valid;
            alu_result    <= s2_is_mul ? (s2_hi ? s2_prod[63:32] : s2_prod[31:0]) : s2_result;
            alu_rob_index <= s2_rob;
            alu_jump      <= s2_jump;
            alu_target_PC <= s2_target;
        end
    end
`else
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            alu_ready <= 1'b0; alu_result <= '0; alu_rob_index <= '0;
            alu_jump <= 1'b0; alu_target_PC <= '0;
        end else if (clr_in) begin
            alu_ready <= 1'b0;
        end else if (rdy_in) begin
            alu_ready     <= rs_to_alu_ready;
            alu_result    <= c_result;
            alu_rob_index <= rs_to_alu_rob_index;
            alu_jump      <= c_jump;
            alu_target_PC <= c_target;
        end
    end
`endif
endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - randomized + directed bench for alu_unit against a behavioural model
module tb_alu_unit;
    localparam int ROB_W = 4;
`ifdef ALU_MUL_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam logic [2:0] T_REG = 3'd0, T_IMM = 3'd1, T_LUI = 3'd2, T_AUIPC = 3'd3,
                           T_JAL = 3'd4, T_JALR = 3'd5, T_BRANCH = 3'd6;
    localparam logic [4:0] O_ADD = 5'd0, O_SUB = 5'd1, O_SLL = 5'd2, O_SLT = 5'd3,
                           O_SLTU = 5'd4, O_XOR = 5'd5, O_SRL = 5'd6, O_SRA = 5'd7,
                           O_OR = 5'd8, O_AND = 5'd9, O_BEQ = 5'd10, O_BNE = 5'd11,
                           O_BLT = 5'd12, O_BGE = 5'd13, O_BLTU = 5'd14, O_BGEU = 5'd15,
                           O_MUL = 5'd16, O_MULH = 5'd17, O_MULHSU = 5'd18, O_MULHU = 5'd19;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, clr_in, rs_to_alu_ready;
    logic [4:0]       rs_to_alu_op;
    logic [2:0]       rs_to_alu_opType;
    logic [31:0]      rs_to_alu_rs1, rs_to_alu_rs2, rs_to_alu_imm, rs_to_alu_PC;
    logic [ROB_W-1:0] rs_to_alu_rob_index;
    logic             alu_ready, alu_jump;
    logic [31:0]      alu_result, alu_target_PC;
    logic [ROB_W-1:0] alu_rob_index;

    alu_unit #(.ROB_W(ROB_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .rs_to_alu_ready(rs_to_alu_ready), .rs_to_alu_op(rs_to_alu_op),
        .rs_to_alu_opType(rs_to_alu_opType), .rs_to_alu_rs1(rs_to_alu_rs1),
        .rs_to_alu_rs2(rs_to_alu_rs2), .rs_to_alu_imm(rs_to_alu_imm),
        .rs_to_alu_PC(rs_to_alu_PC), .rs_to_alu_rob_index(rs_to_alu_rob_index),
        .alu_ready(alu_ready), .alu_result(alu_result), .alu_rob_index(alu_rob_index),
        .alu_jump(alu_jump), .alu_target_PC(alu_target_PC)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0]      result;
        logic [31:0]      target;
        logic             jump;
        logic [ROB_W-1:0] rob;
        int               due;
    } exp_t;

    exp_t q[$];
    exp_t last;
    logic last_ready;
    int   cyc, n_checks, n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    endtask

    function automatic exp_t model(input logic [4:0] op, input logic [2:0] typ,
                                   input logic [31:0] a, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [31:0] pc,
                                   input logic [ROB_W-1:0] rob);
        exp_t e;
        logic [31:0] b;
        longint p;
        b = (typ == T_IMM) ? imm : rs2;
        e.result = 32'd0; e.jump = 1'b0; e.target = pc + 32'd4; e.rob = rob; e.due = 0;
        p = 0;
        case (typ)
            T_REG, T_IMM: begin
                case (op)
                    O_ADD:  e.result = a + b;
                    O_SUB:  e.result = a - b;
                    O_SLL:  e.result = a << b[4:0];
                    O_SLT:  e.result = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    O_SLTU: e.result = (a < b) ? 32'd1 : 32'd0;
                    O_XOR:  e.result = a ^ b;
                    O_SRL:  e.result = a >> b[4:0];
                    O_SRA:  e.result = 32'(int'(a) >>> b[4:0]);
                    O_OR:   e.result = a | b;
                    O_AND:  e.result = a & b;
`ifdef ALU_MUL_EN
                    O_MUL:    begin p = longint'(a) * longint'(b);                  e.result = p[31:0];  end
                    O_MULH:   begin p = longint'(int'(a)) * longint'(int'(b));      e.result = p[63:32]; end
                    O_MULHSU: begin p = longint'(int'(a)) * longint'({32'd0, b});   e.result = p[63:32]; end
                    O_MULHU:  begin p = longint'({32'd0, a}) * longint'({32'd0, b}); e.result = p[63:32]; end
`endif
                    default: e.result = 32'd0;
                endcase
            end
            T_LUI:   e.result = imm;
            T_AUIPC: e.result = pc + imm;
            T_JAL:   begin e.result = pc + 32'd4; e.jump = 1'b1; e.target = pc + imm; end
            T_JALR:  begin e.result = pc + 32'd4; e.jump = 1'b1; e.target = (a + imm) & 32'hFFFF_FFFE; end
            T_BRANCH: begin
                case (op)
                    O_BEQ:  e.jump = (a == b);
                    O_BNE:  e.jump = (a != b);
                    O_BLT:  e.jump = (int'(a) < int'(b));
                    O_BGE:  e.jump = (int'(a) >= int'(b));
                    O_BLTU: e.jump = (a < b);
                    O_BGEU: e.jump = (a >= b);
                    default: e.jump = 1'b0;
                endcase
                if (e.jump) e.target = pc + imm;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, "_ready"},  {31'd0, alu_ready}, 32'd1);
        check({tag, "_result"}, alu_result, e.result);
        check({tag, "_rob"},    {{(32-ROB_W){1'b0}}, alu_rob_index}, {{(32-ROB_W){1'b0}}, e.rob});
        check({tag, "_jump"},   {31'd0, alu_jump}, {31'd0, e.jump});
        check({tag, "_target"}, alu_target_PC, e.target);
    endtask

    // One clock: log any accepted op, advance, then compare against the scoreboard.
    task automatic step();
        exp_t e;
        if (clr_in) begin
            q.delete();
        end else if (rdy_in && rs_to_alu_ready) begin
            e = model(rs_to_alu_op, rs_to_alu_opType, rs_to_alu_rs1, rs_to_alu_rs2,
                      rs_to_alu_imm, rs_to_alu_PC, rs_to_alu_rob_index);
            e.due = cyc + LAT;
            q.push_back(e);
        end
        @(posedge clk_in);
        #1;
        if (clr_in) begin
            cyc++;
            check("clr_ready", {31'd0, alu_ready}, 32'd0);
            last_ready = 1'b0;
        end else if (rdy_in) begin
            cyc++;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                compare_out("op", e);
                last = e;
                last_ready = 1'b1;
            end else begin
                check("bubble_ready", {31'd0, alu_ready}, 32'd0);
                last_ready = 1'b0;
            end
        end else begin
            check("hold_ready", {31'd0, alu_ready}, {31'd0, last_ready});
            if (last_ready) compare_out("hold", last);
        end
    endtask

    task automatic set_op(input logic [4:0] op, input logic [2:0] typ, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [ROB_W-1:0] rob);
        rs_to_alu_ready = 1'b1; rs_to_alu_op = op; rs_to_alu_opType = typ;
        rs_to_alu_rs1 = a; rs_to_alu_rs2 = b; rs_to_alu_imm = imm; rs_to_alu_PC = pc;
        rs_to_alu_rob_index = rob;
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] typ, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [ROB_W-1:0] rob);
        set_op(op, typ, a, b, imm, pc, rob);
        step();
    endtask

    task automatic idle(input int n);
        rs_to_alu_ready = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_op();
        int r;
        logic [31:0] imm;
        logic [2:0] typ;
        logic [4:0] op;
        typ = 3'($urandom_range(0, 6));
        case (typ)
            T_REG:    begin r = $urandom_range(0, 13); op = 5'(r < 10 ? r : r + 6); end
            T_IMM:    begin r = $urandom_range(0, 8);  op = 5'(r == 0 ? 0 : r + 1); end
            T_BRANCH: op = 5'(10 + $urandom_range(0, 5));
            default:  op = 5'($urandom_range(0, 19));
        endcase
        imm = $urandom;
        if ($urandom_range(0, 1) == 0) imm = {{20{imm[11]}}, imm[11:0]};
        set_op(op, typ, $urandom, $urandom, imm, $urandom & 32'hFFFF_FFFC, ROB_W'($urandom));
        if ($urandom_range(0, 3) == 0) rs_to_alu_rs2 = rs_to_alu_rs1;
        rs_to_alu_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; last_ready = 1'b0;
        last = '{default: '0};
        rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
        set_op(O_ADD, T_REG, 0, 0, 0, 0, 0);
        rs_to_alu_ready = 1'b0;
        #3;
        check("rst_ready",  {31'd0, alu_ready}, 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_rob",    {{(32-ROB_W){1'b0}}, alu_rob_index}, 32'd0);
        check("rst_jump",   {31'd0, alu_jump}, 32'd0);
        check("rst_target", alu_target_PC, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(2);

        issue(O_ADD, T_REG, 32'd5, 32'd7, 32'd0, 32'h0, 4'd1);
        issue(O_SRA, T_IMM, 32'hF000_0000, 32'h0, 32'd4, 32'h4, 4'd2);
        idle(LAT + 1);

        issue(O_BLT,  T_BRANCH, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd3);
        issue(O_BLTU, T_BRANCH, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd4);
        issue(O_ADD,  T_JALR,   32'h1003, 32'd0, 32'd2, 32'h40, 4'd0);
        idle(LAT + 1);

        issue(O_ADD, T_REG, 32'd1, 32'd2, 32'd0, 32'h0, 4'd5);
        issue(O_XOR, T_REG, 32'hFF, 32'h0F, 32'd0, 32'h0, 4'd6);
        set_op(O_OR, T_REG, 32'h1, 32'h2, 32'd0, 32'h0, 4'd7);
        clr_in = 1'b1;
        step();
        clr_in = 1'b0;
        idle(LAT + 2);

        issue(O_SLL, T_IMM, 32'h1, 32'h0, 32'd31, 32'h8, 4'd8);
        issue(O_SUB, T_REG, 32'd3, 32'd5, 32'd0, 32'hC, 4'd9);
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_op(O_AND, T_REG, $urandom, $urandom, $urandom, $urandom, 4'd15);
            step();
        end
        rdy_in = 1'b1;
        idle(LAT + 2);

`ifdef ALU_MUL_EN
        issue(O_MULH,   T_REG, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h0, 4'd10);
        issue(O_MULHSU, T_REG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 4'd11);
        issue(O_MULHU,  T_REG, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0, 4'd12);
        issue(O_MUL,    T_REG, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'h0, 4'd13);
`else
        issue(O_MUL,    T_REG, 32'd3, 32'd5, 32'd0, 32'h0, 4'd10);
`endif
        idle(LAT + 1);

        issue(O_ADD, T_REG, 32'd1, 32'd1, 32'd0, 32'h0, 4'd1);
        issue(O_ADD, T_REG, 32'd2, 32'd2, 32'd0, 32'h0, 4'd2);
        issue(O_ADD, T_REG, 32'd3, 32'd3, 32'd0, 32'h0, 4'd3);
        #2 rst_in = 1'b0;
        #1;
        check("mid_rst_ready",  {31'd0, alu_ready}, 32'd0);
        check("mid_rst_result", alu_result, 32'd0);
        check("mid_rst_rob",    {{(32-ROB_W){1'b0}}, alu_rob_index}, 32'd0);
        check("mid_rst_jump",   {31'd0, alu_jump}, 32'd0);
        check("mid_rst_target", alu_target_PC, 32'd0);
        q.delete();
        last_ready = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(LAT + 3);

        for (int i = 0; i < 600; i++) begin
            rand_op();
            rdy_in = ($urandom_range(0, 9) != 0);
            clr_in = ($urandom_range(0, 39) == 0);
            step();
        end
        rdy_in = 1'b1;
        clr_in = 1'b0;
        idle(LAT + 2);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
